// File: rtl/scr1_imem_req_buf_pkg.sv
// Shared IMEM interface types and constants for the instruction-memory request buffer.
package scr1_imem_req_buf_pkg;

   localparam int SCR1_IMEM_AWIDTH             = 32;
   localparam int SCR1_IMEM_DWIDTH             = 32;
   localparam int SCR1_IMEM_BUF_OUTST_MAX_DFLT = 2;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

endpackage : scr1_imem_req_buf_pkg

// File: rtl/scr1_imem_req_buf.sv
// IMEM request buffer: 1-entry request slot, outstanding counter, in-order response return.
// Define SCR1_IMEM_BUF_RESP_REG_EN to register the response path (one extra cycle of latency).
module scr1_imem_req_buf
   import scr1_imem_req_buf_pkg::*;
#(
   parameter int OUTST_MAX = SCR1_IMEM_BUF_OUTST_MAX_DFLT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        pipe2imem_req_i,
   input  type_scr1_mem_cmd_e          pipe2imem_cmd_i,
   input  logic [SCR1_IMEM_AWIDTH-1:0] pipe2imem_addr_i,
   output logic                        imem2pipe_req_ack_o,
   output logic [SCR1_IMEM_DWIDTH-1:0] imem2pipe_rdata_o,
   output type_scr1_mem_resp_e         imem2pipe_resp_o,
   output logic                        buf2imem_req_o,
   output type_scr1_mem_cmd_e          buf2imem_cmd_o,
   output logic [SCR1_IMEM_AWIDTH-1:0] buf2imem_addr_o,
   input  logic                        imem2buf_req_ack_i,
   input  logic [SCR1_IMEM_DWIDTH-1:0] imem2buf_rdata_i,
   input  type_scr1_mem_resp_e         imem2buf_resp_i,
   output logic                        buf_busy_o,
   output logic                        buf_unexp_resp_o
);

   localparam int CNT_W = $clog2(OUTST_MAX + 1);

   logic                        slot_vld;
   type_scr1_mem_cmd_e          slot_cmd;
   logic [SCR1_IMEM_AWIDTH-1:0] slot_addr;
   logic [CNT_W-1:0]            cnt;
   logic                        unexp;

   logic ack;
   logic accept;
   logic fab_resp;
   logic fwd;
   logic dec;

   // Outputs are forced idle while rst_n is low, not just after the reset edge.
   assign ack      = rst_n & ~slot_vld & (cnt < CNT_W'(OUTST_MAX));
   assign accept   = pipe2imem_req_i & ack;
   assign fab_resp = (imem2buf_resp_i != SCR1_MEM_RESP_NOTRDY);

`ifdef SCR1_IMEM_BUF_RESP_REG_EN
   type_scr1_mem_resp_e         resp_r;
   logic [SCR1_IMEM_DWIDTH-1:0] rdata_r;

   // A response sitting in resp_r is still counted in cnt, so exclude it when judging a new one.
   assign dec = (resp_r != SCR1_MEM_RESP_NOTRDY);
   assign fwd = fab_resp & (cnt > CNT_W'(dec));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_r  <= SCR1_MEM_RESP_NOTRDY;
         rdata_r <= '0;
      end else begin
         resp_r  <= fwd ? imem2buf_resp_i : SCR1_MEM_RESP_NOTRDY;
         rdata_r <= imem2buf_rdata_i;
      end
   end

   assign imem2pipe_resp_o  = rst_n ? resp_r : SCR1_MEM_RESP_NOTRDY;
   assign imem2pipe_rdata_o = rst_n ? rdata_r : '0;
`else
   assign fwd = fab_resp & (cnt != '0);
   assign dec = fwd;

   assign imem2pipe_resp_o  = (rst_n & fwd) ? imem2buf_resp_i : SCR1_MEM_RESP_NOTRDY;
   assign imem2pipe_rdata_o = rst_n ? imem2buf_rdata_i : '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_vld  <= 1'b0;
         slot_cmd  <= SCR1_MEM_CMD_RD;
         slot_addr <= '0;
         cnt       <= '0;
         unexp     <= 1'b0;
      end else begin
         if (accept) begin
            slot_vld  <= 1'b1;
            slot_cmd  <= pipe2imem_cmd_i;
            slot_addr <= pipe2imem_addr_i;
         end else if (imem2buf_req_ack_i) begin
            slot_vld  <= 1'b0;
         end
         case ({accept, dec})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (fab_resp & ~fwd) unexp <= 1'b1;
      end
   end

   assign imem2pipe_req_ack_o = ack;
   assign buf2imem_req_o      = rst_n & slot_vld;
   assign buf2imem_cmd_o      = slot_cmd;
   assign buf2imem_addr_o     = slot_addr;
   assign buf_busy_o          = rst_n & (slot_vld | (cnt != '0));
   assign buf_unexp_resp_o    = rst_n & unexp;

`ifndef SYNTHESIS
   a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({pipe2imem_req_i, imem2buf_resp_i, buf2imem_req_o, imem2pipe_resp_o}));
   a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (buf2imem_req_o & ~imem2buf_req_ack_i) |=> ($stable(buf2imem_addr_o) && $stable(buf2imem_cmd_o)));
   a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
      cnt <= CNT_W'(OUTST_MAX));
`endif

endmodule : scr1_imem_req_buf

// File: tb/tb_scr1_imem_req_buf.sv
// Randomized scoreboard bench for scr1_imem_req_buf: transaction-count model plus fabric memory model.
module tb_scr1_imem_req_buf;
   import scr1_imem_req_buf_pkg::*;

   localparam int OUTST_MAX = 2;
`ifdef SCR1_IMEM_BUF_RESP_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                pipe_req = 1'b0;
   type_scr1_mem_cmd_e  pipe_cmd = SCR1_MEM_CMD_RD;
   logic [31:0]         pipe_addr = '0;
   logic                ack_o;
   logic [31:0]         rdata_o;
   type_scr1_mem_resp_e resp_o;
   logic                req_o;
   type_scr1_mem_cmd_e  cmd_o;
   logic [31:0]         addr_o;
   logic                fab_ack = 1'b0;
   logic [31:0]         fab_rdata = '0;
   type_scr1_mem_resp_e fab_resp = SCR1_MEM_RESP_NOTRDY;
   logic                busy;
   logic                unexp;

   scr1_imem_req_buf #(.OUTST_MAX(OUTST_MAX)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .pipe2imem_req_i     (pipe_req),
      .pipe2imem_cmd_i     (pipe_cmd),
      .pipe2imem_addr_i    (pipe_addr),
      .imem2pipe_req_ack_o (ack_o),
      .imem2pipe_rdata_o   (rdata_o),
      .imem2pipe_resp_o    (resp_o),
      .buf2imem_req_o      (req_o),
      .buf2imem_cmd_o      (cmd_o),
      .buf2imem_addr_o     (addr_o),
      .imem2buf_req_ack_i  (fab_ack),
      .imem2buf_rdata_i    (fab_rdata),
      .imem2buf_resp_i     (fab_resp),
      .buf_busy_o          (busy),
      .buf_unexp_resp_o    (unexp)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus knobs
   bit pipe_en = 0, hold_req = 0, inject = 0, injected = 0;
   int p_req = 50, p_ack = 50, p_resp = 50;

   // reference model: transaction counts and ordered expectations
   int          n_acc = 0, n_fack = 0, n_deliv = 0;
   bit          exp_unexp = 0;
   logic [31:0] slot_addr_m = '0;
   logic [31:0] exp_q[$];
   int          cyc_q[$];
   logic [31:0] fab_q[$];

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      return a[13:12] == 2'b01;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // pipe driver
   initial forever begin
      @(posedge clk); #1;
      if (hold_req) begin
         pipe_req  = 1'b1;
         pipe_addr = 32'h200;
      end else if (pipe_en) begin
         pipe_req  = ($urandom % 100) < p_req;
         pipe_addr = $urandom & 32'h0000_3FFC;
      end else begin
         pipe_req  = 1'b0;
      end
   end

   // fabric model: in-order memory with random ack and response timing
   initial begin
      bit          prev_req, prev_ack;
      logic [31:0] prev_addr, a;
      prev_req = 0; prev_ack = 0; prev_addr = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            fab_q.delete();
            prev_req = 0;
         end
         if (prev_req && prev_ack) fab_q.push_back(prev_addr);
         if (prev_req && !prev_ack) begin
            chk("addr_stable", addr_o, prev_addr);
            chk("cmd_stable", 32'(cmd_o), 32'(SCR1_MEM_CMD_RD));
         end
         fab_ack  = req_o && (($urandom % 100) < p_ack);
         injected = 0;
         if (inject) begin
            fab_resp  = SCR1_MEM_RESP_RDY_OK;
            fab_rdata = $urandom;
            injected  = 1;
         end else if (fab_q.size() > 0 && (($urandom % 100) < p_resp)) begin
            a         = fab_q.pop_front();
            fab_resp  = is_err(a) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            fab_rdata = mem_data(a);
            cyc_q.push_back(cyc);
         end else begin
            fab_resp  = SCR1_MEM_RESP_NOTRDY;
            fab_rdata = $urandom;
         end
         prev_req  = req_o;
         prev_ack  = fab_ack;
         prev_addr = addr_o;
      end
   end

   // monitor / scoreboard
   bit          e_slot, e_ack;
   logic [31:0] ea;
   int          ec;
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ack", 32'(ack_o), 0);
         chk("rst_req_o", 32'(req_o), 0);
         chk("rst_resp", 32'(resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
         chk("rst_busy", 32'(busy), 0);
         chk("rst_unexp", 32'(unexp), 0);
         n_acc = 0; n_fack = 0; n_deliv = 0; exp_unexp = 0;
         exp_q.delete(); cyc_q.delete();
      end else begin
         e_slot = (n_acc != n_fack);
         e_ack  = !e_slot && ((n_acc - n_deliv) < OUTST_MAX);
         chk("ack", 32'(ack_o), 32'(e_ack));
         chk("req_o", 32'(req_o), 32'(e_slot));
         chk("busy", 32'(busy), 32'((n_acc != n_deliv) || e_slot));
         chk("unexp", 32'(unexp), 32'(exp_unexp));
         if (e_slot) chk("addr_o", addr_o, slot_addr_m);
         if (resp_o != SCR1_MEM_RESP_NOTRDY) begin
            if (exp_q.size() == 0) begin
               chk("resp_without_request", 32'(resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
            end else begin
               ea = exp_q.pop_front();
               chk("resp", 32'(resp_o),
                   32'(is_err(ea) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK));
               chk("rdata", rdata_o, mem_data(ea));
               ec = (cyc_q.size() > 0) ? cyc_q.pop_front() : -100;
               chk("latency", cyc - ec, LAT);
            end
            n_deliv++;
         end
         if (pipe_req && e_ack) begin
            exp_q.push_back(pipe_addr);
            slot_addr_m = pipe_addr;
            n_acc++;
         end
         if (e_slot && fab_ack) n_fack++;
         if (injected) exp_unexp = 1;
      end
   end

   task automatic run_phase(input int pr, input int pa, input int ps, input int n);
      p_req = pr; p_ack = pa; p_resp = ps; pipe_en = 1;
      repeat (n) @(posedge clk);
   endtask

   task automatic drain();
      pipe_en = 0; p_ack = 100; p_resp = 60;
      for (int i = 0; i < 300 && (n_acc != n_deliv || n_acc != n_fack); i++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("drain_outstanding", n_acc - n_deliv, 0);
   endtask

   initial begin
      rst_n = 0; hold_req = 1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1; hold_req = 0;
      run_phase(50, 60, 40, 400);
      run_phase(90, 100, 5, 300);   // fabric takes requests but holds responses
      run_phase(80, 15, 60, 300);   // long fabric request stalls
      run_phase(100, 100, 100, 300);
      drain();
      // unexpected response with nothing outstanding
      @(negedge clk); inject = 1;
      @(posedge clk); #3 inject = 0;
      repeat (6) @(posedge clk);
      chk("unexp_sticky", 32'(unexp), 1);
      #2 rst_n = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      run_phase(60, 70, 50, 200);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      nerr++;
      $display("FAIL timeout: simulation did not complete at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $fatal(1, "timeout");
   end

endmodule : tb_scr1_imem_req_buf
